// File: rtl/adder_tree_pkg.sv
// Shared types and sizing helpers for the adder tree family.
// The serial variant uses the accumulator width helper below.
package adder_tree_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int GROUP_DEFAULT = 4;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

  function automatic int acc_width(input int width, input int group);
    return width + $clog2(group);
  endfunction

endpackage

// File: rtl/adder_tree4_8_serial.sv
// Byte-serial adder tree: sums each group of GROUP operands and
// presents the modulo-2^WIDTH result with an overflow flag.
module adder_tree4_8_serial
  import adder_tree_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int GROUP = GROUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  input  logic             out_ready
);

  localparam int AW = acc_width(WIDTH, GROUP);
  localparam int CW = $clog2(GROUP);
  localparam logic [CW-1:0] LAST = CW'(GROUP - 1);

  acc_state_t    state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [AW-1:0] din;

  assign din = {{(AW-WIDTH){1'b0}}, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (clear) begin
            acc <= '0;
            cnt <= '0;
          end else if (in_valid) begin
            acc <= acc + din;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // drain cycle doubles as the first accept of the next group
          if (out_ready) begin
            acc   <= in_valid ? din : '0;
            cnt   <= in_valid ? CW'(1) : '0;
            state <= ACCUM;
          end
        end
      endcase
    end
  end

  always_comb begin
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    out_sum      = '0;
    out_overflow = 1'b0;
    if (state == HOLD) begin
      in_ready     = out_ready;
      out_valid    = 1'b1;
      out_sum      = acc[WIDTH-1:0];
      out_overflow = |acc[AW-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_adder_tree4_8_serial.sv
// Randomized and directed scoreboard bench for adder_tree4_8_serial.
// Expected sums come from a group-of-operands queue model.
module tb_adder_tree4_8_serial;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sum;
  logic       out_overflow;
  logic       out_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int sum;
    bit ov;
  } exp_t;

  exp_t exp_q[$];
  int   grp[$];
  int   pop_cyc[$];
  bit   hold = 1'b0;

  adder_tree4_8_serial dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_sum(out_sum),
    .out_overflow(out_overflow),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // reference model: collect accepted operands, emit a sum per group
  always @(negedge clk) begin
    if (rst) begin
      grp.delete();
      exp_q.delete();
      hold = 1'b0;
    end else begin
      bit h, rdy, clr, tk;
      int s;
      h   = hold;
      rdy = !h || out_ready;
      clr = clear && !h;
      tk  = in_valid && rdy && !clr;
      chk(out_valid == h, "model_out_valid", int'(out_valid), int'(h));
      chk(in_ready == rdy, "model_in_ready", int'(in_ready), int'(rdy));
      if (h && out_ready) hold = 1'b0;
      if (clr) grp.delete();
      if (tk) begin
        grp.push_back(int'(in_data));
        if (grp.size() == G) begin
          s = 0;
          foreach (grp[i]) s += grp[i];
          exp_q.push_back('{s % 256, s >= 256});
          grp.delete();
          hold = 1'b1;
        end
      end
    end
  end

  bit         stall = 1'b0;
  logic [7:0] held_sum;
  logic       held_ov;

  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      exp_t e;
      if (stall) begin
        chk(out_valid == 1'b1, "stall_valid", int'(out_valid), 1);
        chk(out_sum == held_sum, "stall_sum",
            int'(out_sum), int'(held_sum));
        chk(out_overflow == held_ov, "stall_ov",
            int'(out_overflow), int'(held_ov));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_sum", int'(out_sum), -1);
        end else begin
          e = exp_q.pop_front();
          chk(out_sum == 8'(e.sum), "sb_sum", int'(out_sum), e.sum);
          chk(out_overflow == e.ov, "sb_ov",
              int'(out_overflow), int'(e.ov));
        end
        pop_cyc.push_back(cyc);
      end
      stall    = out_valid && !out_ready;
      held_sum = out_sum;
      held_ov  = out_overflow;
    end
  end

  task automatic send(input logic [7:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk(1'b0, "send_timeout", n, 50);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic expect_out(input int s, input bit ov, input string nm);
    @(negedge clk);
    chk(out_valid == 1'b1, {nm, "_valid"}, int'(out_valid), 1);
    chk(out_sum == 8'(s), {nm, "_sum"}, int'(out_sum), s);
    chk(out_overflow == ov, {nm, "_ov"}, int'(out_overflow), int'(ov));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(in_ready == 1'b1, {nm, "_in_ready"}, int'(in_ready), 1);
    chk(out_valid == 1'b0, {nm, "_out_valid"}, int'(out_valid), 0);
    chk(out_sum == 8'd0, {nm, "_out_sum"}, int'(out_sum), 0);
    chk(out_overflow == 1'b0, {nm, "_out_ov"}, int'(out_overflow), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    out_ready = 1'b1;
    #1;
    chk_reset_outs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    send4(8'd4, 8'd5, 8'd11, 8'd9);
    expect_out(29, 1'b0, "g29");
    send4(8'd15, 8'd3, 8'd200, 8'd7);
    expect_out(225, 1'b0, "g225");
    send4(8'd200, 8'd100, 8'd0, 8'd0);
    expect_out(44, 1'b1, "g44");
    send4(8'd255, 8'd255, 8'd255, 8'd255);
    expect_out(252, 1'b1, "g252");

    // back-pressure with a waiting operand
    send(8'd1);
    send(8'd2);
    send(8'd3);
    out_ready = 1'b0;
    send(8'd4);
    in_valid = 1'b1;
    in_data  = 8'd8;
    repeat (5) begin
      @(negedge clk);
      chk(in_ready == 1'b0, "bp_in_ready", int'(in_ready), 0);
      chk(out_sum == 8'd10, "bp_sum", int'(out_sum), 10);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'd8);
    send(8'd1);
    send(8'd1);
    send(8'd1);
    expect_out(11, 1'b0, "bp_next");

    // back-to-back groups
    pop_cyc.delete();
    t0 = cyc;
    repeat (8) send(8'd1);
    chk(cyc - t0 == 8, "b2b_no_stall", cyc - t0, 8);
    @(negedge clk);
    #1;
    chk(pop_cyc.size() == 2, "b2b_count", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2)
      chk(pop_cyc[1] - pop_cyc[0] == 4, "b2b_spacing",
          pop_cyc[1] - pop_cyc[0], 4);
    @(posedge clk);
    #1;

    // clear discards partial group and same-cycle operand
    send(8'd50);
    send(8'd60);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    expect_out(10, 1'b0, "clr10");

    // async reset mid-group
    send(8'd7);
    send(8'd8);
    send(8'd9);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_group");
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // async reset mid-hold
    out_ready = 1'b0;
    send4(8'd100, 8'd100, 8'd100, 8'd1);
    @(negedge clk);
    chk(out_valid == 1'b1, "hold_pre_rst", int'(out_valid), 1);
    chk(out_sum == 8'd45, "hold_pre_sum", int'(out_sum), 45);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_hold");
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send4(8'd10, 8'd20, 8'd30, 8'd40);
    expect_out(100, 1'b0, "post_rst");

    // randomized traffic
    repeat (400) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
